pic_host_sequencer: RTL and testbench
=====================================

# pic_host_sequencer

CPU-side master for the PIC control logic. After reset it programs the PIC by issuing the initialization command word (ICW) write strobes and an initial interrupt-mask write. It then services `INT` by generating the two-pulse active-low `ACK` (interrupt-acknowledge) sequence and capturing the vector byte the PIC presents. In non-auto-EOI mode it also issues the end-of-interrupt (EOI) command. It sits between the processor model and `PIC_controlLogic`, driving the same strobes and data bus the control logic consumes.

## Interface
- `ICW1_VAL`, 8'h0B, ICW1 byte; bit0 (IC4) selects whether ICW4 is written, bit1 (SNGL) skips ICW3 when 1.
- `ICW2_VAL`, 8'hA8, vector base byte.
- `ICW3_VAL`, 8'h00, cascade byte; written only when SNGL=0.
- `ICW4_VAL`, 8'h03, bit1 (AEOI) suppresses the EOI write.
- `OCW1_VAL`, 8'h00, initial mask.
- `ACK_LOW`, 2, cycles each `ACK` pulse is held low (≥1).
- `ACK_HIGH`, 2, cycles `ACK` is held high between the two pulses (≥1).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `INT`  in  1  interrupt request from the PIC.
- `CTRL_LOGIC_DATA`  in  8  vector byte driven by the PIC.
- `OUT_CTRL_LOGIC_DATA`  in  1  PIC is driving a valid `CTRL_LOGIC_DATA`.
- `mask_wr`  in  1  one-cycle request to write a new mask.
- `mask_data`  in  8  new mask, sampled when `mask_wr`=1.
- `internal_data_bus`  out  8  command byte.
- `write_ICW_1`, `write_ICW_2_4`, `write_OCW_1`, `write_OCW_2`, `write_OCW_3`  out  1 each  one-cycle write strobes.
- `ACK`  out  1  active-low interrupt acknowledge.
- `irq_vector`  out  8  last captured vector.
- `irq_valid`  out  1  one-cycle pulse marking a new `irq_vector`.
- `irq_spurious`  out  1  one-cycle pulse: second pulse ended without `OUT_CTRL_LOGIC_DATA`.
- `init_done`  out  1  level; high once the init sequence completes.

## Operation
- All outputs are registered.
- Reset values:
  - strobes 0, `ACK`=1, `internal_data_bus`=0.
  - `irq_vector`=0, `irq_valid`=0, `irq_spurious`=0, `init_done`=0.
  - mask-pending flag cleared; FSM in `S_ICW1`.
- Write protocol: each command uses one strobe cycle, with the byte on `internal_data_bus` in the same cycle. A one-cycle gap (all strobes 0, bus holds the byte) follows every write.
- Init order: ICW1 (`write_ICW_1`) → ICW2 → [ICW3 if SNGL=0] → [ICW4 if IC4=1] → OCW1 (`OCW1_VAL`).
  - ICW2, ICW3 and ICW4 all use `write_ICW_2_4`.
  - `init_done` rises in the gap cycle after OCW1 and stays high until reset.
- FSM states: `S_ICW1`, `S_ICW2`, `S_ICW3`, `S_ICW4`, `S_OCW1`, `S_GAP`, `S_IDLE`, `S_ACK1`, `S_ACKH`, `S_ACK2`, `S_DONE`, `S_EOI`, `S_MASK`.
- `S_IDLE`:
  - If `INT`=1, go to `S_ACK1`.
  - Otherwise, if a mask is pending, go to `S_MASK`.
  - `INT` has priority over a pending mask.
- `S_ACK1`: `ACK`=0 for `ACK_LOW` cycles. `S_ACKH`: `ACK`=1 for `ACK_HIGH` cycles. `S_ACK2`: `ACK`=0 for `ACK_LOW` cycles.
- Vector capture: on the last cycle of `S_ACK2`, if `OUT_CTRL_LOGIC_DATA`=1, latch `CTRL_LOGIC_DATA`. Otherwise flag the interrupt as spurious.
- `S_DONE` (one cycle, `ACK`=1):
  - Pulse `irq_valid` after a capture, or `irq_spurious` if none occurred.
  - Then go to `S_EOI` if AEOI=0 (write 8'h20 via `write_OCW_2`, non-specific EOI), else to `S_IDLE`.
- Once `S_ACK1` is entered, `INT` is not re-checked; both pulses always complete.
- `mask_wr` at any time sets the pending flag and overwrites the stored mask (last write wins). `S_MASK` writes the stored mask via `write_OCW_1`, then clears the flag unless a new `mask_wr` arrives in the same cycle.
- `write_OCW_3` is tied to 0 in this revision.
- Asserting `reset` mid-sequence forces the reset values immediately and restarts init from ICW1.

## Timing
- Init with defaults (SNGL=1, IC4=1), counting cycle 1 as the first rising edge after `reset` falls:
  - strobes at cycles 1, 3, 5, 7 (ICW1, ICW2, ICW4, OCW1).
  - `init_done`=1 from cycle 8; FSM in `S_IDLE` from cycle 9.
- IRQ with defaults, `INT` sampled at edge N:
  - `ACK` low N+1..N+2, high N+3..N+4, low N+5..N+6.
  - `irq_valid` at N+7.
  - `write_OCW_2` at N+8 when AEOI=0 (gap at N+9, `S_IDLE` at N+10); `S_IDLE` at N+8 when AEOI=1.
- Minimum spacing between `ACK` sequences is 1 cycle (AEOI=1).
- `irq_vector` holds its value until the next capture.

## Structure
- Shared package `pic_host_pkg` holds:
  - the state enum.
  - `EOI_NONSPEC`=8'h20.
  - bit indices `ICW1_IC4`=0, `ICW1_SNGL`=1, `ICW4_AEOI`=1.
- One sub-module, `pic_host_pulse_timer`: loadable down-counter with a `done` flag, reused for the `ACK_LOW` and `ACK_HIGH` phases.

## Test plan
- Reset release with defaults → strobes at cycles 1, 3, 5, 7 with bytes 8'h0B, 8'hA8, 8'h03, 8'h00; `init_done` at cycle 8.
- `ICW1_VAL`=8'h08 (SNGL=0, IC4=0), `ICW3_VAL`=8'h04 → ICW1, ICW2, ICW3 written; no ICW4; then OCW1.
- `INT`=1 with the PIC returning 8'hA9 and `OUT_CTRL_LOGIC_DATA`=1 in the second pulse → `ACK` pattern 0,0,1,1,0,0; `irq_vector`=8'hA9 with `irq_valid` at N+7; no `write_OCW_2` (AEOI=1).
- `ICW4_VAL`=8'h01, same interrupt → `write_OCW_2` with data 8'h20 at N+8.
- `INT` dropped at N+2 and no `OUT_CTRL_LOGIC_DATA` → both pulses complete; `irq_spurious` at N+7; `irq_vector` unchanged.
- `mask_wr`=8'h0F during init and `mask_wr`=8'hF0 coincident with `INT` → 8'h0F written right after init; 8'hF0 written via `write_OCW_1` only after the IRQ sequence returns to `S_IDLE`.

Source files
------------

// File: rtl/pic_host_pkg.sv
// Shared definitions for the PIC host sequencer.
//   state_t      : sequencer FSM state encoding
//   EOI_NONSPEC  : OCW2 byte for a non-specific end-of-interrupt
//   ICW1_IC4, ICW1_SNGL, ICW4_AEOI : bit positions inside the ICW bytes
package pic_host_pkg;

  typedef enum logic [3:0] {
    S_ICW1,
    S_ICW2,
    S_ICW3,
    S_ICW4,
    S_OCW1,
    S_GAP,
    S_IDLE,
    S_ACK1,
    S_ACKH,
    S_ACK2,
    S_DONE,
    S_EOI,
    S_MASK
  } state_t;

  localparam logic [7:0] EOI_NONSPEC = 8'h20;

  localparam int unsigned ICW1_IC4  = 0;
  localparam int unsigned ICW1_SNGL = 1;
  localparam int unsigned ICW4_AEOI = 1;

endpackage

// File: rtl/pic_host_pulse_timer.sv
// Loadable down-counter timing the ACK low/high phases.
//   clk, reset : clock and asynchronous active-high reset
//   load       : load a new phase length (takes priority over counting)
//   load_val   : phase length in cycles (>= 1)
//   done       : high during the last cycle of the loaded phase
module pic_host_pulse_timer
  import pic_host_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Loading length-1 means done is seen on exactly the load_val-th cycle
  // after the load edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pic_host_sequencer.sv
// CPU-side master for the PIC control logic: programs ICW1..ICW4 and the
// initial mask after reset, then answers INT with the two-pulse ACK
// sequence, captures the vector, and issues EOI when not in auto-EOI mode.
//   clk, reset            : clock, asynchronous active-high reset
//   INT                   : interrupt request from the PIC
//   CTRL_LOGIC_DATA       : vector byte driven by the PIC
//   OUT_CTRL_LOGIC_DATA   : PIC is driving a valid vector byte
//   mask_wr, mask_data    : request to write a new interrupt mask
//   internal_data_bus     : command byte for the current write
//   write_ICW_1, write_ICW_2_4, write_OCW_1, write_OCW_2, write_OCW_3 : strobes
//   ACK                   : active-low interrupt acknowledge
//   irq_vector, irq_valid : last captured vector, pulse on new capture
//   irq_spurious          : pulse when the second ACK pulse got no vector
//   init_done             : high once initialisation has completed
module pic_host_sequencer
  import pic_host_pkg::*;
#(
  parameter logic [7:0]  ICW1_VAL = 8'h0B,
  parameter logic [7:0]  ICW2_VAL = 8'hA8,
  parameter logic [7:0]  ICW3_VAL = 8'h00,
  parameter logic [7:0]  ICW4_VAL = 8'h03,
  parameter logic [7:0]  OCW1_VAL = 8'h00,
  parameter int unsigned ACK_LOW  = 2,
  parameter int unsigned ACK_HIGH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INT,
  input  logic [7:0] CTRL_LOGIC_DATA,
  input  logic       OUT_CTRL_LOGIC_DATA,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  output logic [7:0] internal_data_bus,
  output logic       write_ICW_1,
  output logic       write_ICW_2_4,
  output logic       write_OCW_1,
  output logic       write_OCW_2,
  output logic       write_OCW_3,
  output logic       ACK,
  output logic [7:0] irq_vector,
  output logic       irq_valid,
  output logic       irq_spurious,
  output logic       init_done
);

  localparam logic IC4  = ICW1_VAL[ICW1_IC4];
  localparam logic SNGL = ICW1_VAL[ICW1_SNGL];
  // AEOI only exists when ICW4 is actually written; otherwise the PIC
  // keeps its cleared ICW4 and expects an explicit EOI.
  localparam logic AEOI = IC4 & ICW4_VAL[ICW4_AEOI];

  localparam logic [7:0] LOW_CNT  = 8'(ACK_LOW);
  localparam logic [7:0] HIGH_CNT = 8'(ACK_HIGH);

  state_t     state;
  state_t     gap_next;
  logic       mask_pend;
  logic [7:0] mask_reg;
  logic [7:0] cap_vec;
  logic       cap_ok;

  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_done;

  pic_host_pulse_timer #(.W(8)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // The timer is loaded on the edge that enters each ACK phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = LOW_CNT;
    unique case (state)
      S_IDLE: tmr_load = INT;
      S_ACK1: begin
        tmr_load = tmr_done;
        tmr_val  = HIGH_CNT;
      end
      S_ACKH: tmr_load = tmr_done;
      default: ;
    endcase
  end

  assign write_OCW_3 = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_ICW1;
      gap_next          <= S_ICW1;
      mask_pend         <= 1'b0;
      mask_reg          <= '0;
      cap_vec           <= '0;
      cap_ok            <= 1'b0;
      internal_data_bus <= '0;
      write_ICW_1       <= 1'b0;
      write_ICW_2_4     <= 1'b0;
      write_OCW_1       <= 1'b0;
      write_OCW_2       <= 1'b0;
      ACK               <= 1'b1;
      irq_vector        <= '0;
      irq_valid         <= 1'b0;
      irq_spurious      <= 1'b0;
      init_done         <= 1'b0;
    end else begin
      write_ICW_1   <= 1'b0;
      write_ICW_2_4 <= 1'b0;
      write_OCW_1   <= 1'b0;
      write_OCW_2   <= 1'b0;
      irq_valid     <= 1'b0;
      irq_spurious  <= 1'b0;

      if (mask_wr) begin
        mask_reg  <= mask_data;
        mask_pend <= 1'b1;
      end

      unique case (state)
        S_ICW1: begin
          write_ICW_1       <= 1'b1;
          internal_data_bus <= ICW1_VAL;
          gap_next          <= S_ICW2;
          state             <= S_GAP;
        end
        S_ICW2: begin
          write_ICW_2_4     <= 1'b1;
          internal_data_bus <= ICW2_VAL;
          gap_next          <= !SNGL ? S_ICW3 : (IC4 ? S_ICW4 : S_OCW1);
          state             <= S_GAP;
        end
        S_ICW3: begin
          write_ICW_2_4     <= 1'b1;
          internal_data_bus <= ICW3_VAL;
          gap_next          <= IC4 ? S_ICW4 : S_OCW1;
          state             <= S_GAP;
        end
        S_ICW4: begin
          write_ICW_2_4     <= 1'b1;
          internal_data_bus <= ICW4_VAL;
          gap_next          <= S_OCW1;
          state             <= S_GAP;
        end
        S_OCW1: begin
          write_OCW_1       <= 1'b1;
          internal_data_bus <= OCW1_VAL;
          gap_next          <= S_IDLE;
          state             <= S_GAP;
        end
        // Shared post-write gap; the first gap returning to idle ends init.
        S_GAP: begin
          state <= gap_next;
          if (gap_next == S_IDLE) init_done <= 1'b1;
        end
        S_IDLE: begin
          if (INT)            state <= S_ACK1;
          else if (mask_pend) state <= S_MASK;
        end
        S_ACK1: begin
          ACK <= 1'b0;
          if (tmr_done) state <= S_ACKH;
        end
        S_ACKH: begin
          ACK <= 1'b1;
          if (tmr_done) state <= S_ACK2;
        end
        S_ACK2: begin
          ACK <= 1'b0;
          if (tmr_done) begin
            cap_ok <= OUT_CTRL_LOGIC_DATA;
            if (OUT_CTRL_LOGIC_DATA) cap_vec <= CTRL_LOGIC_DATA;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          ACK <= 1'b1;
          if (cap_ok) begin
            irq_vector <= cap_vec;
            irq_valid  <= 1'b1;
          end else begin
            irq_spurious <= 1'b1;
          end
          state <= AEOI ? S_IDLE : S_EOI;
        end
        S_EOI: begin
          write_OCW_2       <= 1'b1;
          internal_data_bus <= EOI_NONSPEC;
          gap_next          <= S_IDLE;
          state             <= S_GAP;
        end
        S_MASK: begin
          write_OCW_1       <= 1'b1;
          internal_data_bus <= mask_reg;
          if (!mask_wr) mask_pend <= 1'b0;
          gap_next          <= S_IDLE;
          state             <= S_GAP;
        end
        default: state <= S_ICW1;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Directed bench for pic_host_sequencer. Three instances share all inputs:
//   inst0 defaults (SNGL=1, IC4=1, AEOI=1)
//   inst1 ICW1=08, ICW3=04 (SNGL=0, IC4=0 -> EOI issued)
//   inst2 ICW4=01 (AEOI=0 -> EOI issued)
module tb_pic_host_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       INT = 1'b0;
  logic [7:0] ctrl_data = 8'h00;
  logic       ctrl_valid = 1'b0;
  logic       mask_wr = 1'b0;
  logic [7:0] mask_data = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic [7:0] bus_a, bus_b, bus_c, vec_a, vec_b, vec_c;
  logic icw1_a, icw24_a, ocw1_a, ocw2_a, ocw3_a, ack_a, val_a, spur_a, done_a;
  logic icw1_b, icw24_b, ocw1_b, ocw2_b, ocw3_b, ack_b, val_b, spur_b, done_b;
  logic icw1_c, icw24_c, ocw1_c, ocw2_c, ocw3_c, ack_c, val_c, spur_c, done_c;

  pic_host_sequencer u_a (
    .clk(clk), .reset(reset), .INT(INT), .CTRL_LOGIC_DATA(ctrl_data),
    .OUT_CTRL_LOGIC_DATA(ctrl_valid), .mask_wr(mask_wr), .mask_data(mask_data),
    .internal_data_bus(bus_a), .write_ICW_1(icw1_a), .write_ICW_2_4(icw24_a),
    .write_OCW_1(ocw1_a), .write_OCW_2(ocw2_a), .write_OCW_3(ocw3_a),
    .ACK(ack_a), .irq_vector(vec_a), .irq_valid(val_a),
    .irq_spurious(spur_a), .init_done(done_a)
  );

  pic_host_sequencer #(.ICW1_VAL(8'h08), .ICW3_VAL(8'h04)) u_b (
    .clk(clk), .reset(reset), .INT(INT), .CTRL_LOGIC_DATA(ctrl_data),
    .OUT_CTRL_LOGIC_DATA(ctrl_valid), .mask_wr(mask_wr), .mask_data(mask_data),
    .internal_data_bus(bus_b), .write_ICW_1(icw1_b), .write_ICW_2_4(icw24_b),
    .write_OCW_1(ocw1_b), .write_OCW_2(ocw2_b), .write_OCW_3(ocw3_b),
    .ACK(ack_b), .irq_vector(vec_b), .irq_valid(val_b),
    .irq_spurious(spur_b), .init_done(done_b)
  );

  pic_host_sequencer #(.ICW4_VAL(8'h01)) u_c (
    .clk(clk), .reset(reset), .INT(INT), .CTRL_LOGIC_DATA(ctrl_data),
    .OUT_CTRL_LOGIC_DATA(ctrl_valid), .mask_wr(mask_wr), .mask_data(mask_data),
    .internal_data_bus(bus_c), .write_ICW_1(icw1_c), .write_ICW_2_4(icw24_c),
    .write_OCW_1(ocw1_c), .write_OCW_2(ocw2_c), .write_OCW_3(ocw3_c),
    .ACK(ack_c), .irq_vector(vec_c), .irq_valid(val_c),
    .irq_spurious(spur_c), .init_done(done_c)
  );

  // strobe order: {ICW1, ICW2_4, OCW1, OCW2, OCW3}
  logic [4:0] strb [3];
  logic [7:0] bus  [3];
  logic [7:0] vec  [3];
  logic       ack  [3];
  logic [2:0] flg  [3]; // {irq_valid, irq_spurious, init_done}

  assign strb[0] = {icw1_a, icw24_a, ocw1_a, ocw2_a, ocw3_a};
  assign strb[1] = {icw1_b, icw24_b, ocw1_b, ocw2_b, ocw3_b};
  assign strb[2] = {icw1_c, icw24_c, ocw1_c, ocw2_c, ocw3_c};
  assign bus[0] = bus_a;
  assign bus[1] = bus_b;
  assign bus[2] = bus_c;
  assign vec[0] = vec_a;
  assign vec[1] = vec_b;
  assign vec[2] = vec_c;
  assign ack[0] = ack_a;
  assign ack[1] = ack_b;
  assign ack[2] = ack_c;
  assign flg[0] = {val_a, spur_a, done_a};
  assign flg[1] = {val_b, spur_b, done_b};
  assign flg[2] = {val_c, spur_c, done_c};

  logic [7:0] icw1_byte [3] = '{8'h0B, 8'h08, 8'h0B};
  logic [7:0] third_byte [3] = '{8'h03, 8'h04, 8'h01}; // ICW4 / ICW3 / ICW4
  bit         aeoi [3] = '{1'b1, 1'b0, 1'b0};

  // Checks everything that must hold while reset is (or just went) high.
  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (strb[i] !== 5'b0 || bus[i] !== 8'h00) begin
        errors++;
        $display("FAIL %s_bus inst%0d: strb %b bus %h, want 00000 00", tag, i, strb[i], bus[i]);
      end
      checks++;
      if (ack[i] !== 1'b1 || vec[i] !== 8'h00 || flg[i] !== 3'b000) begin
        errors++;
        $display("FAIL %s_out inst%0d: ack %b vec %h flags %b, want 1 00 000",
                 tag, i, ack[i], vec[i], flg[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
  endtask

  // Called at a negedge; releases reset so the next posedge is cycle 1.
  task automatic test_init(input bit with_mask);
    logic [4:0] es;
    logic [7:0] eb;
    reset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (with_mask && k == 2) begin
        mask_wr = 1'b1;
        mask_data = 8'h0F;
      end else begin
        mask_wr = 1'b0;
      end
      es = 5'b00000;
      if (k == 1) es = 5'b10000;
      else if (k == 3 || k == 5) es = 5'b01000;
      else if (k == 7 || (k == 10 && with_mask)) es = 5'b00100;
      for (int i = 0; i < 3; i++) begin
        if (k <= 2) eb = icw1_byte[i];
        else if (k <= 4) eb = 8'hA8;
        else if (k <= 6) eb = third_byte[i];
        else if (k <= 9) eb = 8'h00;
        else eb = with_mask ? 8'h0F : 8'h00;
        checks++;
        if (strb[i] !== es || bus[i] !== eb) begin
          errors++;
          $display("FAIL init_write inst%0d cyc%0d: strb %b bus %h, want %b %h",
                   i, k, strb[i], bus[i], es, eb);
        end
        checks++;
        if (flg[i][0] !== (k >= 8) || ack[i] !== 1'b1) begin
          errors++;
          $display("FAIL init_done inst%0d cyc%0d: init_done %b ack %b, want %b 1",
                   i, k, flg[i][0], ack[i], (k >= 8));
        end
      end
    end
  endtask

  // Shared per-cycle ACK checks are written inline in each IRQ task.
  task automatic test_irq_vector();
    logic el;
    INT = 1'b1;
    ctrl_data = 8'hA9;
    @(posedge clk);
    @(negedge clk);
    INT = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      ctrl_valid = (k == 4 || k == 5);
      el = !(k == 1 || k == 2 || k == 5 || k == 6);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ack[i] !== el) begin
          errors++;
          $display("FAIL irq_ack inst%0d N+%0d: got %b want %b", i, k, ack[i], el);
        end
        checks++;
        if (flg[i][2:1] !== {(k == 7), 1'b0}) begin
          errors++;
          $display("FAIL irq_valid inst%0d N+%0d: valid/spur %b want %b%b",
                   i, k, flg[i][2:1], (k == 7), 1'b0);
        end
        checks++;
        if (strb[i][1] !== (!aeoi[i] && k == 8)) begin
          errors++;
          $display("FAIL irq_eoi inst%0d N+%0d: ocw2 %b want %b", i, k, strb[i][1],
                   (!aeoi[i] && k == 8));
        end
        if (k == 7) begin
          checks++;
          if (vec[i] !== 8'hA9) begin
            errors++;
            $display("FAIL irq_vec inst%0d: got %h want a9", i, vec[i]);
          end
        end
        if (k == 8 && !aeoi[i]) begin
          checks++;
          if (bus[i] !== 8'h20) begin
            errors++;
            $display("FAIL irq_eoi_bus inst%0d: got %h want 20", i, bus[i]);
          end
        end
      end
    end
  endtask

  task automatic test_spurious();
    logic el;
    INT = 1'b1;
    ctrl_data = 8'h5A;
    ctrl_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      INT = 1'b0;
      el = !(k == 1 || k == 2 || k == 5 || k == 6);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ack[i] !== el) begin
          errors++;
          $display("FAIL spur_ack inst%0d N+%0d: got %b want %b", i, k, ack[i], el);
        end
        checks++;
        if (flg[i][2:1] !== {1'b0, (k == 7)}) begin
          errors++;
          $display("FAIL spur_flag inst%0d N+%0d: valid/spur %b want 0%b",
                   i, k, flg[i][2:1], (k == 7));
        end
        checks++;
        if (vec[i] !== 8'hA9) begin
          errors++;
          $display("FAIL spur_vec inst%0d N+%0d: got %h want a9", i, k, vec[i]);
        end
      end
    end
  endtask

  // Mask requested in the same cycle as INT: IRQ wins, mask follows in idle.
  task automatic test_mask_during_irq();
    int mk;
    INT = 1'b1;
    mask_wr = 1'b1;
    mask_data = 8'hF0;
    ctrl_data = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    INT = 1'b0;
    mask_wr = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      ctrl_valid = (k == 4 || k == 5);
      for (int i = 0; i < 3; i++) begin
        mk = aeoi[i] ? 9 : 11;
        checks++;
        if (strb[i][2] !== (k == mk)) begin
          errors++;
          $display("FAIL mask_strobe inst%0d N+%0d: ocw1 %b want %b", i, k, strb[i][2], (k == mk));
        end
        if (k == mk) begin
          checks++;
          if (bus[i] !== 8'hF0) begin
            errors++;
            $display("FAIL mask_bus inst%0d: got %h want f0", i, bus[i]);
          end
        end
        if (k == 7) begin
          checks++;
          if (vec[i] !== 8'h3C || flg[i][2] !== 1'b1) begin
            errors++;
            $display("FAIL mask_irq_vec inst%0d: vec %h valid %b want 3c 1", i, vec[i], flg[i][2]);
          end
        end
      end
    end
  endtask

  // Reset during ACK with a mask pending: everything returns to reset values
  // and the pending mask is forgotten.
  task automatic test_reset_mid();
    INT = 1'b1;
    @(posedge clk);
    @(negedge clk);
    INT = 1'b0;
    mask_wr = 1'b1;
    mask_data = 8'h55;
    @(negedge clk);
    mask_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ack[i] !== 1'b0) begin
        errors++;
        $display("FAIL mid_ack_low inst%0d: got %b want 0", i, ack[i]);
      end
    end
    #2 reset = 1'b1;
    #1 check_reset_values("mid_reset");
    @(negedge clk);
    test_init(1'b0);
  endtask

  initial begin
    test_reset();
    test_init(1'b1);
    test_irq_vector();
    test_spurious();
    test_mask_during_irq();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
